// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and a per-grant
// quantum that forces rotation when an owner hogs the resource under contention.
module ring_rr_arbiter #(
   parameter  int N       = 4,
   parameter  int QUANTUM = 8,
   localparam int IDW     = $clog2(N)
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic [N-1:0]   Req,
   output logic [N-1:0]   Grant,
   output logic           Grant_valid,
   output logic [IDW-1:0] Grant_id,
   output logic           Preempt,
   output logic [N-1:0]   Ptr
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam int             CW       = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
   localparam logic [CW-1:0]  HOLD_MAX = CW'(QUANTUM - 1);

   logic [0:0]     state_q,   state_d;
   logic [N-1:0]   grant_q,   grant_d;
   logic           valid_q,   valid_d;
   logic [IDW-1:0] id_q,      id_d;
   logic           preempt_q, preempt_d;
   logic [N-1:0]   ptr_q,     ptr_d;
   logic [CW-1:0]  hold_q,    hold_d;

   // First set bit of cand, scanning upward from the one-hot ptr and wrapping.
   function automatic logic [N-1:0] ring_pick(input logic [N-1:0] cand,
                                              input logic [N-1:0] ptr);
      logic [N-1:0] res;
      logic         found;
      int           base;
      int           j;
      res   = '0;
      found = 1'b0;
      base  = 0;
      for (int i = 0; i < N; i++) begin
         if (ptr[i]) base = i;
      end
      for (int k = 0; k < N; k++) begin
         j = (base + k) % N;
         if (!found && cand[j]) begin
            res[j] = 1'b1;
            found  = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [IDW-1:0] encode(input logic [N-1:0] onehot);
      logic [IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot[i]) idx = IDW'(i);
      end
      return idx;
   endfunction

   logic [N-1:0] others;
   logic [N-1:0] others_win;
   logic [N-1:0] idle_win;
   logic [N-1:0] owner_next_ptr;
   logic         owner_req;

   assign others         = Req & ~grant_q;
   assign others_win     = ring_pick(others, ptr_q);
   assign idle_win       = ring_pick(Req, ptr_q);
   assign owner_req      = |(Req & grant_q);
   assign owner_next_ptr = {grant_q[N-2:0], grant_q[N-1]};

   always_comb begin
      // NOTE: every next-state signal gets a default first so no branch leaves one unassigned (which would infer a latch).
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (|Req) begin
               grant_d = idle_win;
               hold_d  = '0;
               state_d = BUSY;
            end
         end
         default: begin
            if (!owner_req) begin
               ptr_d  = owner_next_ptr;
               hold_d = '0;
               if (|others) begin
                  grant_d = others_win;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + CW'(1);
            end else if (|others) begin
               // Quantum used up with competitors waiting: hand over on this edge.
               grant_d   = others_win;
               preempt_d = 1'b1;
               ptr_d     = owner_next_ptr;
               hold_d    = '0;
            end
         end
      endcase

      valid_d = |grant_d;
      id_d    = encode(grant_d);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         preempt_q <= 1'b0;
         ptr_q     <= N'(1);
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         preempt_q <= preempt_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
      end
   end

   assign Grant       = grant_q;
   assign Grant_valid = valid_q;
   assign Grant_id    = id_q;
   assign Preempt     = preempt_q;
   assign Ptr         = ptr_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter: directed Req vectors push hand-computed
// expectations; a monitor pops and compares one entry after each rising edge.
module tb_ring_rr_arbiter;

   localparam int N       = 4;
   localparam int QUANTUM = 8;

   logic         Clock;
   logic         Reset;
   logic [N-1:0] Req;
   logic [N-1:0] Grant;
   logic         Grant_valid;
   logic [1:0]   Grant_id;
   logic         Preempt;
   logic [N-1:0] Ptr;

   ring_rr_arbiter #(.N(N), .QUANTUM(QUANTUM)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Req        (Req),
      .Grant      (Grant),
      .Grant_valid(Grant_valid),
      .Grant_id   (Grant_id),
      .Preempt    (Preempt),
      .Ptr        (Ptr)
   );

   typedef struct packed {
      logic [3:0] grant;
      logic       valid;
      logic [1:0] id;
      logic       preempt;
      logic [3:0] ptr;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb_q.size());
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] enc(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Drive Req for one cycle and queue what the outputs must be after the next edge.
   task automatic step(input string tag, input logic [3:0] req, input logic [3:0] g,
                       input logic p, input logic [3:0] ptr);
      exp_t e;
      @(negedge Clock);
      Req       = req;
      e.grant   = g;
      e.valid   = |g;
      e.id      = enc(g);
      e.preempt = p;
      e.ptr     = ptr;
      sb_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge Clock);
   endtask

   initial begin
      exp_t  e;
      string t;
      forever begin
         @(posedge Clock);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".grant"},   32'(Grant),       32'(e.grant));
            check({t, ".valid"},   32'(Grant_valid), 32'(e.valid));
            check({t, ".id"},      32'(Grant_id),    32'(e.id));
            check({t, ".preempt"}, 32'(Preempt),     32'(e.preempt));
            check({t, ".ptr"},     32'(Ptr),         32'(e.ptr));
         end
      end
   end

   initial begin
      Reset = 1'b1;
      Req   = '0;
      #17;
      check("reset.grant",   32'(Grant),       32'h0);
      check("reset.valid",   32'(Grant_valid), 32'h0);
      check("reset.id",      32'(Grant_id),    32'h0);
      check("reset.preempt", 32'(Preempt),     32'h0);
      check("reset.ptr",     32'(Ptr),         32'h1);
      @(negedge Clock);
      Reset = 1'b0;

      // Single requester: one-edge latency, release to idle advances Ptr.
      step("idle0",   4'b0000, 4'b0000, 1'b0, 4'b0001);
      step("single",  4'b0001, 4'b0001, 1'b0, 4'b0001);
      step("rel_idl", 4'b0000, 4'b0000, 1'b0, 4'b0010);

      // All requesting, each owner releases after two cycles: gapless handoff.
      step("rr_g1",   4'b1111, 4'b0010, 1'b0, 4'b0010);
      step("rr_h1",   4'b1111, 4'b0010, 1'b0, 4'b0010);
      step("rr_g2",   4'b1101, 4'b0100, 1'b0, 4'b0100);
      step("rr_h2",   4'b1111, 4'b0100, 1'b0, 4'b0100);
      step("rr_g3",   4'b1011, 4'b1000, 1'b0, 4'b1000);
      step("rr_h3",   4'b1111, 4'b1000, 1'b0, 4'b1000);
      step("rr_g0",   4'b0111, 4'b0001, 1'b0, 4'b0001);
      step("rr_h0",   4'b1111, 4'b0001, 1'b0, 4'b0001);
      step("rr_g1b",  4'b1110, 4'b0010, 1'b0, 4'b0010);
      step("rr_end",  4'b0000, 4'b0000, 1'b0, 4'b0100);

      // Wrap-around scan: Ptr=1000, Req=0101 picks bit 0.
      step("w_g2",    4'b0100, 4'b0100, 1'b0, 4'b0100);
      step("w_rel",   4'b0000, 4'b0000, 1'b0, 4'b1000);
      step("wrap",    4'b0101, 4'b0001, 1'b0, 4'b1000);
      step("w_end",   4'b0000, 4'b0000, 1'b0, 4'b0010);

      // Quantum expiry: owner 0 keeps the grant exactly QUANTUM cycles.
      step("q_g0",    4'b0001, 4'b0001, 1'b0, 4'b0010);
      for (int i = 1; i < QUANTUM; i++)
         step("q_hold", 4'b0101, 4'b0001, 1'b0, 4'b0010);
      step("q_pre",   4'b0101, 4'b0100, 1'b1, 4'b0010);
      step("q_post",  4'b0101, 4'b0100, 1'b0, 4'b0010);
      step("q_end",   4'b0000, 4'b0000, 1'b0, 4'b1000);

      // Lone owner beyond the quantum: no preempt; counter saturated, so the
      // first competitor takes over on the very next edge.
      for (int i = 0; i < 20; i++)
         step("lone",  4'b0010, 4'b0010, 1'b0, 4'b1000);
      step("sat_pre", 4'b1010, 4'b1000, 1'b1, 4'b0100);
      step("sat_h",   4'b1010, 4'b1000, 1'b0, 4'b0100);
      step("to_g2",   4'b0100, 4'b0100, 1'b0, 4'b0001);
      step("g2_h",    4'b0100, 4'b0100, 1'b0, 4'b0001);

      // Asynchronous reset mid-grant, checked before any clock edge.
      @(negedge Clock);
      #2;
      Reset = 1'b1;
      Req   = 4'b0000;
      #1;
      check("areset.grant", 32'(Grant),       32'h0);
      check("areset.valid", 32'(Grant_valid), 32'h0);
      check("areset.id",    32'(Grant_id),    32'h0);
      check("areset.ptr",   32'(Ptr),         32'h1);
      #1;
      Reset = 1'b0;
      step("rst_g1",  4'b0110, 4'b0010, 1'b0, 4'b0001);
      step("rst_end", 4'b0000, 4'b0000, 1'b0, 4'b0100);

      repeat (2) @(posedge Clock);
      #2;
      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
